// File: rtl/life_generation_sequencer_if.sv
// Control/status bundle between the board loader/UI and the Game-of-Life generation sequencer.
interface life_generation_sequencer_if #(
  parameter int GRID_W = 8,
  parameter int GRID_H = 8,
  parameter int GEN_W  = 16
);
  logic                       load_valid;
  logic [GRID_W*GRID_H-1:0]   load_data;
  logic                       start;
  logic                       busy;
  logic                       done;
  logic                       stable;
  logic [GEN_W-1:0]           gen_count;
  logic [GRID_W*GRID_H-1:0]   grid_out;

  modport master (
    output load_valid, load_data, start,
    input  busy, done, stable, gen_count, grid_out
  );

  modport slave (
    input  load_valid, load_data, start,
    output busy, done, stable, gen_count, grid_out
  );
endinterface

// File: rtl/life_generation_sequencer.sv
// Computes one Game-of-Life generation on a toroidal grid, one cell per clock,
// into a shadow buffer that is committed as the new board in a single cycle.
module life_generation_sequencer #(
  parameter int GRID_W = 8,
  parameter int GRID_H = 8,
  parameter int GEN_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  life_generation_sequencer_if.slave  bus
);
  localparam int N  = GRID_W * GRID_H;
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int IW = $clog2(N);

  localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);
  localparam logic [IW-1:0] I_MAX = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t           state;
  logic [N-1:0]     grid;
  logic [N-1:0]     shadow;
  logic [IW-1:0]    idx;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic [GEN_W-1:0] gen_count;
  logic             stable;
  logic             busy;

  // x/y are tracked alongside idx so no divider is needed to locate the cell.
  logic [XW-1:0] x_l, x_r;
  logic [YW-1:0] y_u, y_d;

  assign x_l = (x == '0)    ? X_MAX : x - XW'(1);
  assign x_r = (x == X_MAX) ? '0    : x + XW'(1);
  assign y_u = (y == '0)    ? Y_MAX : y - YW'(1);
  assign y_d = (y == Y_MAX) ? '0    : y + YW'(1);

  function automatic logic [IW-1:0] cell_idx(input logic [XW-1:0] cx, input logic [YW-1:0] cy);
    return IW'(int'(cy) * GRID_W + int'(cx));
  endfunction

  logic [7:0] nbr;
  assign nbr = {grid[cell_idx(x_l, y_u)], grid[cell_idx(x, y_u)], grid[cell_idx(x_r, y_u)],
                grid[cell_idx(x_l, y  )],                         grid[cell_idx(x_r, y  )],
                grid[cell_idx(x_l, y_d)], grid[cell_idx(x, y_d)], grid[cell_idx(x_r, y_d)]};

  logic [3:0] nbr_count;
  logic       next_state;

  always_comb begin
    // NOTE: give every always_comb target a value before any conditional logic so no latch is inferred.
    nbr_count = '0;
    for (int k = 0; k < 8; k++) begin
      nbr_count = nbr_count + 4'(nbr[k]);
    end
    next_state = (nbr_count == 4'd3) || (grid[idx] && (nbr_count == 4'd2));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      // NOTE: the board and its shadow are reset too, because a reset must present an empty board on grid_out.
      grid      <= '0;
      shadow    <= '0;
      idx       <= '0;
      x         <= '0;
      y         <= '0;
      gen_count <= '0;
      stable    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      unique case (state)
        IDLE: begin
          if (bus.load_valid) begin
            grid      <= bus.load_data;
            gen_count <= '0;
            stable    <= 1'b0;
          end else if (bus.start) begin
            idx   <= '0;
            x     <= '0;
            y     <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end

        SCAN: begin
          shadow[idx] <= next_state;
          idx         <= idx + IW'(1);
          if (x == X_MAX) begin
            x <= '0;
            y <= (y == Y_MAX) ? '0 : y + YW'(1);
          end else begin
            x <= x + XW'(1);
          end
          if (idx == I_MAX) begin
            state <= COMMIT;
          end
        end

        COMMIT: begin
          grid      <= shadow;
          stable    <= (shadow == grid);
          gen_count <= gen_count + GEN_W'(1);
          busy      <= 1'b0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = (state == COMMIT);
  assign bus.stable    = stable;
  assign bus.gen_count = gen_count;
  assign bus.grid_out  = grid;

endmodule
